// File: rtl/sp_bram_wrr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sp_bram_arb_pkg
// Shared types and helpers for the single-port BRAM weighted round-robin
// scheduler.
//   N_CLIENTS  : default client count; sizes the response-tag index
//   IDX_W      : width of a client index
//   WEIGHT_W   : width of a per-client weight / credit counter
//   resp_tag_t : one response-pipe entry {vld, idx}
//   w_eff()    : effective weight (a zero weight behaves as one)
// ---------------------------------------------------------------------------
package sp_bram_arb_pkg;

    localparam int unsigned N_CLIENTS = 4;
    localparam int unsigned IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int unsigned WEIGHT_W  = 4;

    // One in-flight read: which client gets the data when it comes back.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } resp_tag_t;

    // A zero weight would otherwise reload credit to all-ones after the
    // decrement, so it is promoted to one grant per turn.
    function automatic logic [WEIGHT_W-1:0] w_eff(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

endpackage : sp_bram_arb_pkg

// File: rtl/sp_bram_wrr_scheduler_if.sv
// ---------------------------------------------------------------------------
// sp_bram_wrr_scheduler_if
// Bundles the client request ports, the weight configuration and the BRAM
// primitive ports of the scheduler.
//   cfg_weight  : per-client grants per turn
//   client_req  : request, held until granted
//   client_gnt  : one-hot grant, combinational
//   client_addr / client_di / client_we : per-client access payload
//   client_do / client_dvld : per-client read return
//   sram_en / sram_we / sram_addr / sram_di : BRAM command
//   sram_do     : BRAM read data
// Modports:
//   slave  : the scheduler
//   master : the clients plus the BRAM model (bench side)
// ---------------------------------------------------------------------------
interface sp_bram_wrr_scheduler_if #(
    parameter int unsigned N            = sp_bram_arb_pkg::N_CLIENTS,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WE_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int unsigned WEIGHT_WIDTH = sp_bram_arb_pkg::WEIGHT_W
);

    logic [N-1:0][WEIGHT_WIDTH-1:0] cfg_weight;
    logic [N-1:0]                   client_req;
    logic [N-1:0]                   client_gnt;
    logic [N-1:0][ADDR_WIDTH-1:0]   client_addr;
    logic [N-1:0][DATA_WIDTH-1:0]   client_di;
    logic [N-1:0][WE_WIDTH-1:0]     client_we;
    logic [N-1:0][DATA_WIDTH-1:0]   client_do;
    logic [N-1:0]                   client_dvld;
    logic                           sram_en;
    logic [WE_WIDTH-1:0]            sram_we;
    logic [ADDR_WIDTH-1:0]          sram_addr;
    logic [DATA_WIDTH-1:0]          sram_di;
    logic [DATA_WIDTH-1:0]          sram_do;

    modport slave (
        input  cfg_weight,
        input  client_req,
        output client_gnt,
        input  client_addr,
        input  client_di,
        input  client_we,
        output client_do,
        output client_dvld,
        output sram_en,
        output sram_we,
        output sram_addr,
        output sram_di,
        input  sram_do
    );

    modport master (
        output cfg_weight,
        output client_req,
        input  client_gnt,
        output client_addr,
        output client_di,
        output client_we,
        input  client_do,
        input  client_dvld,
        input  sram_en,
        input  sram_we,
        input  sram_addr,
        input  sram_di,
        output sram_do
    );

endinterface : sp_bram_wrr_scheduler_if

// File: rtl/sp_bram_wrr_scheduler_pick.sv
// ---------------------------------------------------------------------------
// wrr_pick
// Rotating-priority find-first over the request vector. The search starts
// at i_cur+1, wraps modulo N, and checks i_cur itself last.
//   i_req   : request vector
//   i_cur   : current turn owner
//   o_found : at least one request is present
//   o_idx   : first requester in rotated order (0 when none)
// ---------------------------------------------------------------------------
module wrr_pick
    import sp_bram_arb_pkg::*;
#(
    parameter int unsigned N = N_CLIENTS
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_cur,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_j;

    // Walk offsets 1..N so that the current owner is considered last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_j = IDX_W'((32'(i_cur) + k) % N);
            if (!o_found && i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule : wrr_pick

// File: rtl/sp_bram_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// sp_bram_wrr_scheduler
// Shares one single-port BRAM between N clients with weighted round-robin
// arbitration. At most one access is issued per cycle; read data returns to
// the granted client READ_LATENCY cycles after the grant.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : client request/return ports, weights and BRAM command/data
//           (sp_bram_wrr_scheduler_if.slave)
// N and WEIGHT_WIDTH must match the package constants that size the
// response tag and the weight helper.
// ---------------------------------------------------------------------------
module sp_bram_wrr_scheduler
    import sp_bram_arb_pkg::*;
#(
    parameter int unsigned N            = N_CLIENTS,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WE_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sp_bram_wrr_scheduler_if.slave   bus
);

    // Turn owner and remaining grants in the current turn.
    logic [IDX_W-1:0]        r_cur;
    logic [WEIGHT_WIDTH-1:0] r_credit;

    // Read-return tags; entry READ_LATENCY-1 lines up with sram_do.
    resp_tag_t               r_pipe [READ_LATENCY];

    logic                    w_pick_found;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_hold;
    logic                    w_gnt_vld;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_is_read;
    logic [WEIGHT_WIDTH-1:0] w_reload;

    wrr_pick #(
        .N       (N)
    ) u_pick (
        .i_req   (bus.client_req),
        .i_cur   (r_cur),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // Grant selection: keep the turn while credit remains, else rotate.
    // Reset suppresses every grant so the BRAM sees no command meanwhile.
    always_comb begin
        w_hold    = rst_n && bus.client_req[r_cur] && (r_credit != '0);
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_cur;
        if (w_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_cur;
        end else if (rst_n && w_pick_found) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_pick_idx;
        end
    end

    assign w_gnt_is_read = w_gnt_vld && (bus.client_we[w_gnt_idx] == '0);

    // Weight is sampled only here, at the start of a new turn.
    assign w_reload = w_eff(bus.cfg_weight[w_gnt_idx]) - WEIGHT_WIDTH'(1);

    // BRAM command and grant vector, zero-latency from the grant.
    always_comb begin
        bus.client_gnt = '0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = '0;
        bus.sram_addr  = '0;
        bus.sram_di    = '0;
        if (w_gnt_vld) begin
            bus.client_gnt[w_gnt_idx] = 1'b1;
            bus.sram_en               = 1'b1;
            bus.sram_we               = bus.client_we[w_gnt_idx];
            bus.sram_addr             = bus.client_addr[w_gnt_idx];
            bus.sram_di               = bus.client_di[w_gnt_idx];
        end
    end

    // Turn state. A dropped request loses its remaining credit because the
    // next grant to anyone else reloads credit from scratch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur    <= '0;
            r_credit <= '0;
        end else if (w_hold) begin
            r_credit <= r_credit - WEIGHT_WIDTH'(1);
        end else if (w_gnt_vld) begin
            r_cur    <= w_gnt_idx;
            r_credit <= w_reload;
        end
    end

    // Response pipe: one tag per issued access, writes carry vld=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= '{vld: w_gnt_is_read, idx: w_gnt_idx};
            for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    // Read return: route BRAM data to the tagged client only.
    always_comb begin
        bus.client_dvld = '0;
        bus.client_do   = '0;
        if (rst_n && r_pipe[READ_LATENCY-1].vld) begin
            bus.client_dvld[r_pipe[READ_LATENCY-1].idx] = 1'b1;
            bus.client_do[r_pipe[READ_LATENCY-1].idx]   = bus.sram_do;
        end
    end

endmodule : sp_bram_wrr_scheduler

// File: tb/tb_sp_bram_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sp_bram_wrr_scheduler
// Directed bench for the WRR BRAM scheduler. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sp_bram_wrr_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned WEW = 4;
    localparam int unsigned RL  = 2;
    localparam int unsigned WW  = 4;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [3:0]   exp_g;
    logic [127:0] exp_do;

    int seq_rr  [8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
    int seq_w31 [8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    int seq_fw  [12] = '{0, 0, 0, 0, 3, 3, 0, 3, 3, 0, 3, 0};

    sp_bram_wrr_scheduler_if #(
        .N            (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .WE_WIDTH     (WEW),
        .WEIGHT_WIDTH (WW)
    ) bus ();

    sp_bram_wrr_scheduler #(
        .N            (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .WE_WIDTH     (WEW),
        .READ_LATENCY (RL),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_w(input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3);
        bus.cfg_weight[0] = w0;
        bus.cfg_weight[1] = w1;
        bus.cfg_weight[2] = w2;
        bus.cfg_weight[3] = w3;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.client_req  = 4'hF;
        bus.client_addr = '0;
        bus.client_di   = '0;
        bus.client_we   = '0;
        bus.sram_do     = 32'h5555_AAAA;
        set_w(4'd1, 4'd1, 4'd1, 4'd1);

        // Reset: everything quiet even with requests and BRAM data present.
        tick();
        smp();
        chk("rst_gnt",  128'(bus.client_gnt),  128'(4'b0000));
        chk("rst_en",   128'(bus.sram_en),     128'(1'b0));
        chk("rst_we",   128'(bus.sram_we),     128'(4'h0));
        chk("rst_addr", 128'(bus.sram_addr),   128'(8'h00));
        chk("rst_dvld", 128'(bus.client_dvld), 128'(4'b0000));
        chk("rst_do",   128'(bus.client_do),   128'(0));
        tick();

        // Equal weights, all requesting: 1,2,3,0,... and in-order returns.
        rst_n       = 1'b1;
        bus.sram_do = '0;
        for (int c = 0; c < 10; c++) begin
            bus.client_req = (c < 8) ? 4'hF : 4'h0;
            smp();
            if (c < 8) begin
                exp_g = 4'(4'b0001 << seq_rr[c]);
                chk("rr_gnt", 128'(bus.client_gnt), 128'(exp_g));
                chk("rr_en",  128'(bus.sram_en),    128'(1'b1));
            end else begin
                chk("rr_idle_gnt", 128'(bus.client_gnt), 128'(4'b0000));
                chk("rr_idle_en",  128'(bus.sram_en),    128'(1'b0));
            end
            if (c >= 2) begin
                exp_g = 4'(4'b0001 << seq_rr[c-2]);
                chk("rr_dvld", 128'(bus.client_dvld), 128'(exp_g));
            end
            tick();
        end

        // w0=3, w1=1, clients 0 and 1 requesting.
        set_w(4'd3, 4'd1, 4'd1, 4'd1);
        bus.client_req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            smp();
            exp_g = 4'(4'b0001 << seq_w31[c]);
            chk("w31_gnt", 128'(bus.client_gnt), 128'(exp_g));
            tick();
        end
        bus.client_req = 4'b0000;
        tick();
        tick();
        tick();

        // Client 2 read of 0x10, data back two cycles later.
        set_w(4'd1, 4'd1, 4'd1, 4'd1);
        bus.client_addr[2] = 8'h10;
        bus.client_di[2]   = 32'h0000_A5A5;
        bus.client_we[2]   = 4'h0;
        bus.client_req     = 4'b0100;
        smp();
        chk("rd_gnt",  128'(bus.client_gnt), 128'(4'b0100));
        chk("rd_en",   128'(bus.sram_en),    128'(1'b1));
        chk("rd_we",   128'(bus.sram_we),    128'(4'h0));
        chk("rd_addr", 128'(bus.sram_addr),  128'(8'h10));
        chk("rd_di",   128'(bus.sram_di),    128'(32'h0000_A5A5));
        tick();
        bus.client_req = 4'b0000;
        smp();
        chk("rd_t1_dvld", 128'(bus.client_dvld), 128'(4'b0000));
        tick();
        bus.sram_do = 32'hDEAD_BEEF;
        smp();
        exp_do = '0;
        exp_do[95:64] = 32'hDEAD_BEEF;
        chk("rd_t2_dvld", 128'(bus.client_dvld), 128'(4'b0100));
        chk("rd_t2_do",   bus.client_do,          exp_do);
        tick();
        smp();
        chk("rd_t3_dvld", 128'(bus.client_dvld), 128'(4'b0000));
        chk("rd_t3_do",   bus.client_do,          128'(0));
        tick();

        // Client 1 full-word write: no read return afterwards.
        bus.client_addr[1] = 8'h22;
        bus.client_di[1]   = 32'h1234_5678;
        bus.client_we[1]   = 4'hF;
        bus.client_req     = 4'b0010;
        bus.sram_do        = 32'hCAFE_F00D;
        smp();
        chk("wr_gnt",  128'(bus.client_gnt), 128'(4'b0010));
        chk("wr_we",   128'(bus.sram_we),    128'(4'hF));
        chk("wr_addr", 128'(bus.sram_addr),  128'(8'h22));
        chk("wr_di",   128'(bus.sram_di),    128'(32'h1234_5678));
        tick();
        bus.client_req = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            smp();
            chk("wr_no_dvld", 128'(bus.client_dvld), 128'(4'b0000));
            tick();
        end
        bus.client_we[1] = 4'h0;

        // w0=4, w3=2: client 0 leaves after two grants, client 3 takes over.
        set_w(4'd4, 4'd1, 4'd1, 4'd2);
        bus.client_req = 4'b0001;
        smp();
        chk("fw_a_gnt", 128'(bus.client_gnt), 128'(4'b0001));
        tick();
        bus.client_req = 4'b1001;
        smp();
        chk("fw_b_gnt", 128'(bus.client_gnt), 128'(4'b0001));
        tick();
        bus.client_req = 4'b1000;
        smp();
        chk("fw_c_gnt", 128'(bus.client_gnt), 128'(4'b1000));
        tick();
        bus.client_req = 4'b1001;
        smp();
        chk("fw_d_gnt", 128'(bus.client_gnt), 128'(4'b1000));
        tick();
        // Fresh turn for 0, mid-turn weight change, then zero weights.
        for (int c = 0; c < 12; c++) begin
            if (c == 1) bus.cfg_weight[0] = 4'd1;
            if (c == 8) set_w(4'd0, 4'd0, 4'd0, 4'd0);
            smp();
            exp_g = 4'(4'b0001 << seq_fw[c]);
            chk("fw_seq_gnt", 128'(bus.client_gnt), 128'(exp_g));
            tick();
        end

        // Single requester is granted every cycle.
        bus.client_req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            smp();
            chk("single_gnt", 128'(bus.client_gnt), 128'(4'b0100));
            tick();
        end

        // Reset during in-flight reads drops them.
        set_w(4'd1, 4'd1, 4'd1, 4'd1);
        bus.client_req = 4'b0001;
        smp();
        chk("mr_t0_gnt", 128'(bus.client_gnt), 128'(4'b0001));
        tick();
        bus.client_req = 4'b0011;
        rst_n          = 1'b0;
        smp();
        chk("mr_t1_gnt",  128'(bus.client_gnt),  128'(4'b0000));
        chk("mr_t1_en",   128'(bus.sram_en),     128'(1'b0));
        chk("mr_t1_dvld", 128'(bus.client_dvld), 128'(4'b0000));
        tick();
        rst_n          = 1'b1;
        bus.client_req = 4'b0000;
        for (int c = 2; c <= 4; c++) begin
            smp();
            chk("mr_dvld", 128'(bus.client_dvld), 128'(4'b0000));
            tick();
        end

        // First grant after reset searches from index 1.
        bus.client_req = 4'hF;
        smp();
        chk("post_rst_gnt0", 128'(bus.client_gnt), 128'(4'b0010));
        tick();
        smp();
        chk("post_rst_gnt1", 128'(bus.client_gnt), 128'(4'b0100));
        tick();
        bus.client_req = 4'h0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sp_bram_wrr_scheduler
